// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared constants for the PWM peripheral: bus width and the
//               readback field layout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  localparam int BUS_W    = 32;
  localparam int COMP_LSB = 0;
  localparam int CNT_LSB  = 8;

  // The counter field sits directly above the compare field. For the default
  // WIDTH=8 this lands on CNT_LSB.
  function automatic int cnt_field_lsb(input int width);
    return COMP_LSB + width;
  endfunction

endpackage : pwm_pkg

`default_nettype wire

// File: rtl/pwm_prescaler.sv
// ============================================================================
// Module      : pwm_prescaler
// Description : Divide-by-DIV tick generator; tick_o is high one clock in DIV.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  // A one-bit counter is kept even for DIV=1; it simply stays at zero.
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_q;
  logic [PW-1:0] pre_d;
  logic          tick;

  always_comb begin
    tick  = (pre_q == PRE_LAST);
    pre_d = tick ? '0 : pre_q + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick_o = tick;

endmodule : pwm_prescaler

`default_nettype wire

// File: rtl/pwm.sv
// ============================================================================
// Module      : pwm
// Description : Single-channel bus-programmable PWM with double-buffered duty.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm
  import pwm_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bSel,
  input  logic             bWrite,
  input  logic [BUS_W-1:0] bWData,
  output logic [BUS_W-1:0] bRData,
  output logic             pwmOutput
);

  localparam int              CNT_OFS = cnt_field_lsb(WIDTH);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic             pwm_q,    pwm_d;
  logic             tick;
  logic             wrap;
  logic             unused_wdata;

  assign unused_wdata = ^bWData[BUS_W-1:WIDTH];

  pwm_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // The shadow may be written on the boundary edge too; the active copy then
  // picks up the previous shadow, so the new value waits one more period.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    wrap     = tick && (cnt_q == CNT_MAX);

    if (bSel && bWrite) begin
      shadow_d = bWData[WIDTH-1:0];
    end
    if (tick) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
    if (wrap) begin
      active_d = shadow_q;
    end

    pwm_d = (cnt_q < active_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    bRData = '0;
    if (bSel) begin
      bRData[COMP_LSB +: WIDTH] = shadow_q;
      bRData[CNT_OFS  +: WIDTH] = cnt_q;
    end
  end

  assign pwmOutput = pwm_q;

endmodule : pwm

`default_nettype wire

// File: tb/tb_pwm.sv
// ============================================================================
// Module      : tb_pwm
// Description : Scoreboard bench for pwm at DIV=1 and DIV=3.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm;

  logic        clk = 1'b0;
  logic        rst;
  logic        bSel;
  logic        bWrite;
  logic [31:0] bWData;
  logic [31:0] rd1, rd3;
  logic        pwm1, pwm3;

  always #5 clk = ~clk;

  pwm #(.WIDTH(8), .DIV(1)) u_dut (
    .clk(clk), .rst(rst), .bSel(bSel), .bWrite(bWrite),
    .bWData(bWData), .bRData(rd1), .pwmOutput(pwm1)
  );

  pwm #(.WIDTH(8), .DIV(3)) u_dut3 (
    .clk(clk), .rst(rst), .bSel(bSel), .bWrite(bWrite),
    .bWData(bWData), .bRData(rd3), .pwmOutput(pwm3)
  );

  typedef struct {
    logic        p0;
    logic [31:0] r0;
    logic        p1;
    logic [31:0] r1;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state, index 0 -> DIV=1, index 1 -> DIV=3
  logic [7:0] m_cnt[2], m_sh[2], m_act[2];
  int         m_pre[2];
  logic       m_pwm[2];
  int         m_div[2] = '{1, 3};

  // Run-length tracking on the DIV=1 output
  logic prev1;
  int   run_hi, run_lo, last_hi, last_lo, rise_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 8'h00; m_sh[k] = 8'h00; m_act[k] = 8'h00;
      m_pre[k] = 0;     m_pwm[k] = 1'b0;
    end
    prev1 = 1'b0; run_hi = 0; run_lo = 0; last_hi = -1; last_lo = -1; rise_cnt = -1;
  endtask

  // Drive one clock of bus activity, predict the post-edge outputs, compare.
  task automatic step(input logic sel, input logic wr, input logic [31:0] d);
    exp_t e;
    logic tick, wrap;
    logic [7:0] rsel[2];
    bSel = sel; bWrite = wr; bWData = d;
    for (int k = 0; k < 2; k++) begin
      tick     = (m_pre[k] == m_div[k] - 1);
      wrap     = tick && (m_cnt[k] == 8'hFF);
      m_pwm[k] = (m_cnt[k] < m_act[k]);
      if (wrap) m_act[k] = m_sh[k];
      if (tick) m_cnt[k] = m_cnt[k] + 8'd1;
      m_pre[k] = tick ? 0 : m_pre[k] + 1;
      if (sel && wr) m_sh[k] = d[7:0];
      rsel[k] = m_cnt[k];
    end
    e.p0 = m_pwm[0];
    e.r0 = sel ? {16'h0, rsel[0], m_sh[0]} : 32'h0;
    e.p1 = m_pwm[1];
    e.r1 = sel ? {16'h0, rsel[1], m_sh[1]} : 32'h0;
    sbq.push_back(e);

    @(posedge clk);
    #1;
    e = sbq.pop_front();
    check("pwm_d1",  {31'h0, pwm1}, {31'h0, e.p0});
    check("rd_d1",   rd1,           e.r0);
    check("pwm_d3",  {31'h0, pwm3}, {31'h0, e.p1});
    check("rd_d3",   rd3,           e.r1);

    if (pwm1 && !prev1) begin
      last_lo = run_lo; run_hi = 1;
      if (sel) rise_cnt = int'(rd1[15:8]);
    end else if (pwm1) begin
      run_hi++;
    end else if (prev1) begin
      last_hi = run_hi; run_lo = 1;
    end else begin
      run_lo++;
    end
    prev1 = pwm1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; bSel = 1'b0; bWrite = 1'b0; bWData = 32'h0;
    model_clear();
    #1;
    check("rst_rd_in",  rd1, 32'h0);
    check("rst_pwm_in", {31'h0, pwm1}, 32'h0);
    #20;
    @(posedge clk);
    #1;
    check("rst_rd_hold",  rd1, 32'h0);
    check("rst_pwm_hold", {31'h0, pwm1 | pwm3}, 32'h0);
    rst = 1'b0;
    bSel = 1'b1;
    #1;
    check("rst_comp_sel", {24'h0, rd1[7:0]}, 32'h0);
    check("rst_pwm_out",  {31'h0, pwm1}, 32'h0);
  endtask

  initial begin
    int n;
    int hi_count;

    do_reset();

    // Write and readback
    step(1'b1, 1'b1, 32'h0000_0032);
    step(1'b1, 1'b0, 32'h0);
    check("wr_comp",  {24'h0, rd1[7:0]}, 32'h32);
    check("wr_upper", {16'h0, rd1[31:16]}, 32'h0);

    // Duty 0x32 after first wrap
    run(768);
    check("duty32_hi",   last_hi,  50);
    check("duty32_lo",   last_lo,  206);
    check("duty32_rise", rise_cnt, 1);

    // Double-buffer: write 0x80 in the middle of a 0x32 high phase
    n = 0;
    while (m_cnt[0] != 8'h10 && n < 300) begin
      run(1); n++;
    end
    check("wait_cnt10", {31'h0, n < 300}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_0080);
    check("db_readback", {24'h0, rd1[7:0]}, 32'h80);
    n = 0;
    while (m_cnt[0] != 8'h40 && n < 300) begin
      run(1); n++;
    end
    check("db_cur_hi", last_hi, 50);
    run(400);
    check("db_next_hi", last_hi, 128);

    // Maximum compare
    step(1'b1, 1'b1, 32'h0000_00FF);
    run(768);
    check("ff_hi", last_hi, 255);
    check("ff_lo", last_lo, 1);

    // Zero compare: constant low over three periods once active
    step(1'b1, 1'b1, 32'hFFFF_FF00);
    run(300);
    hi_count = 0;
    for (int i = 0; i < 768; i++) begin
      run(1);
      if (pwm1) hi_count++;
    end
    check("zero_hi_count", hi_count, 0);

    // Unselected write is ignored
    step(1'b0, 1'b1, 32'h0000_00AA);
    step(1'b1, 1'b0, 32'h0);
    check("unsel_wr", {24'h0, rd1[7:0]}, 32'h0);

    // Mid-period asynchronous reset
    step(1'b1, 1'b1, 32'h0000_0080);
    n = 0;
    while (!pwm1 && n < 600) begin
      run(1); n++;
    end
    check("wait_hi", {31'h0, pwm1}, 32'h1);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("mid_rst_pwm", {31'h0, pwm1 | pwm3}, 32'h0);
    check("mid_rst_rd",  rd1, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run(20);
    check("post_rst_comp", {24'h0, rd1[7:0]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL timeout reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule : tb_pwm

`default_nettype wire

// File: doc/pwm.md
Name: pwm

Overview:
- Single-channel, bus-programmable PWM generator.
- A free-running WIDTH-bit counter is compared against a software-written compare value (duty) to produce pwmOutput.
- Sits as a simple slave peripheral on the CPU's select/write bus: one register, no address decode; the bus decoder drives bSel.
- Compare updates are double-buffered so duty changes never glitch mid-period.

Parameters:
- WIDTH, 8, counter/compare width in bits; period = 2^WIDTH counter steps.
- DIV, 1, clock prescaler; counter advances once every DIV clocks (DIV >= 1).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- bSel  input  1  peripheral select from bus decoder.
- bWrite  input  1  write strobe; qualified by bSel.
- bWData  input  32  write data; bits [WIDTH-1:0] = new compare value, upper bits ignored.
- bRData  output  32  read data; combinational.
- pwmOutput  output  1  PWM waveform, registered.

Behaviour:
- Reset (async, rst=1): comp_shadow=0, comp_active=0, cnt=0, prescaler=0, pwmOutput=0. Output stays low throughout reset.
- Write:
  - On a rising edge with bSel=1 and bWrite=1, comp_shadow <= bWData[WIDTH-1:0].
  - bWrite with bSel=0 has no effect.
- Read:
  - bRData = {16'b0, cnt[7:0], comp_shadow[7:0]} when bSel=1, else 32'h0. Layout shown for WIDTH=8; generally comp in [WIDTH-1:0], cnt in [2*WIDTH-1:WIDTH], rest zero.
  - The read is purely combinational, so a write is visible on bRData the cycle after its edge.
  - Readback returns comp_shadow, not comp_active.
- Prescaler:
  - Counts 0..DIV-1; tick=1 when prescaler==DIV-1, then it wraps to 0.
  - With DIV=1, tick is high every clock.
- Counter:
  - On tick, cnt <= cnt+1, wrapping from 2^WIDTH-1 to 0.
  - On the tick where cnt==2^WIDTH-1 (period boundary), comp_active <= comp_shadow.
  - A write on that same edge is not captured; it takes effect at the following boundary.
- Output:
  - Every clock, pwmOutput <= (cnt < comp_active), unsigned compare, one clock of latency.
  - comp=0 gives constant 0; comp=2^WIDTH-1 gives high for 2^WIDTH-1 of 2^WIDTH steps. 100% duty is not reachable (by design).
- Duty: high time = comp_active*DIV clocks per period of 2^WIDTH*DIV clocks.
- First write after reset: comp_active is still 0, so the output stays low until the first counter wrap. With DIV=1 that is up to 256 clocks.
- Reset mid-operation: everything returns to reset values immediately; the written compare is lost.

Decomposition:
- Shared package: bus data width constant (32), readback field offsets (COMP_LSB=0, CNT_LSB=8).
- One natural sub-module, pwm_prescaler: DIV counter producing the tick.
- Counter, double-buffer and compare logic stay in pwm.

Test Plan:
- Reset: hold rst 20 ns, bSel=0 -> bRData=0, pwmOutput=0 during and immediately after reset; with bSel=1, bRData[7:0]=00.
- Write/readback: bSel=1, bWrite=1, bWData=32'h00000032 for one edge; then bSel=1, bWrite=0 -> bRData[7:0]=32, bRData[31:16]=0.
- Duty, DIV=1, comp=0x32:
  - After the first wrap, each 256-clock period has pwmOutput high for exactly 50 consecutive clocks, then low for 206.
  - Rising edge is one clock after cnt reaches 0.
- Extremes:
  - comp=0x00 -> pwmOutput constantly 0 over 3 periods.
  - comp=0xFF -> high 255 clocks, low 1 clock per period.
- Double-buffer: write 0x80 at cnt=0x10 while comp_active=0x32 -> current period keeps 50-clock high; next period high 128 clocks; readback shows 80 immediately.
- Unselected write and mid-run reset:
  - bWrite=1 with bSel=0, bWData=0xAA -> readback unchanged.
  - Assert rst mid-period -> pwmOutput drops to 0 asynchronously and readback comp=00.
